// File: rtl/pool_result_writer_if.sv
// Bundles the producer beat, SRAM write port and layer-control signals of pool_result_writer.
// WR_CHECKSUM_EN adds the checksum signal to both modports.
interface pool_result_writer_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W-1:0] wordCount;
  logic              convValid;
  logic [31:0]       convResult;
  logic              memReady;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              busy;
  logic              done;
  logic              overflow;
`ifdef WR_CHECKSUM_EN
  logic [31:0]       checksum;

  modport master (
    output start, baseAddr, wordCount, convValid, convResult, memReady,
    input  memWe, memAddr, memWdata, busy, done, overflow, checksum
  );
  modport slave (
    input  start, baseAddr, wordCount, convValid, convResult, memReady,
    output memWe, memAddr, memWdata, busy, done, overflow, checksum
  );
`else
  modport master (
    output start, baseAddr, wordCount, convValid, convResult, memReady,
    input  memWe, memAddr, memWdata, busy, done, overflow
  );
  modport slave (
    input  start, baseAddr, wordCount, convValid, convResult, memReady,
    output memWe, memAddr, memWdata, busy, done, overflow
  );
`endif
endinterface

// File: rtl/pool_result_writer.sv
// Captures pooled result beats into a FIFO and writes them to sequential SRAM words; beat-to-write 2 edges.
// No producer backpressure: a full FIFO without a pop drops the beat and sets sticky overflow. Macro WR_CHECKSUM_EN adds a write-data checksum.
module pool_result_writer_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic          wr;

  assign empty = (fill == '0);
  assign full  = (fill == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];
  // Full slot is reusable when the head leaves on the same edge; pop is only raised when non-empty.
  assign wr    = push && (!full || pop) && !clr;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
endmodule

module pool_result_writer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input logic                 clk,
  input logic                 rst,
  pool_result_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] issued;
  logic              zero_pend;
  logic              fifo_empty;
  logic              fifo_full;
  logic [31:0]       fifo_head;
  logic              in_run;
  logic              accept;
  logic              push;
  logic              pop;
  logic              last;
  logic              drop;

  assign in_run = (state == RUN);
  assign accept = (state == IDLE) && !zero_pend && bus.start;
  assign push   = in_run && bus.convValid;
  assign pop    = in_run && !fifo_empty && bus.memReady;
  assign last   = pop && ((issued + ONE) == cnt);
  assign drop   = push && fifo_full && !pop;

  // Surplus beats are flushed by clearing on the final write edge.
  pool_result_writer_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept || last),
    .push     (push),
    .push_dat (bus.convResult),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      base         <= '0;
      cnt          <= '0;
      issued       <= '0;
      zero_pend    <= 1'b0;
      bus.memWe    <= 1'b0;
      bus.memAddr  <= '0;
      bus.memWdata <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
`ifdef WR_CHECKSUM_EN
      bus.checksum <= '0;
`endif
    end else begin
      bus.memWe <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          // A zero-length layer takes one extra IDLE cycle, then reports done with no writes.
          if (zero_pend) begin
            zero_pend <= 1'b0;
            state     <= DONE;
            bus.done  <= 1'b1;
          end else if (accept) begin
            base         <= bus.baseAddr;
            cnt          <= bus.wordCount;
            issued       <= '0;
            bus.overflow <= 1'b0;
`ifdef WR_CHECKSUM_EN
            bus.checksum <= '0;
`endif
            if (bus.wordCount == '0) begin
              zero_pend <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop) begin
            bus.memWe    <= 1'b1;
            bus.memAddr  <= base + issued;
            bus.memWdata <= fifo_head;
            issued       <= issued + ONE;
`ifdef WR_CHECKSUM_EN
            bus.checksum <= bus.checksum + fifo_head;
`endif
          end
          if (drop) bus.overflow <= 1'b1;
          if (last) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_result_writer.sv
// Randomised and directed bench for pool_result_writer against a queue-level reference model.
module tb_pool_result_writer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tot = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_result_writer_if #(.ADDR_W(ADDR_W)) bus ();

  pool_result_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: layer phase, a queue for the FIFO and the expected registered outputs.
  int          mp = 0;   // 0 idle, 1 run, 2 done, 3 zero-count wait
  logic [31:0] m_q[$];
  logic [11:0] m_base = '0, m_cnt = '0, m_iss = '0, m_addr = '0;
  logic [31:0] m_data = '0, m_sum = '0;
  logic        m_we = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mp = 0; m_q.delete();
      m_base = '0; m_cnt = '0; m_iss = '0; m_addr = '0;
      m_data = '0; m_sum = '0; m_we = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      m_we = 1'b0;
      m_done = 1'b0;
      case (mp)
        0: if (bus.start) begin
             m_base = bus.baseAddr; m_cnt = bus.wordCount; m_iss = '0;
             m_ovf = 1'b0; m_sum = '0; m_q.delete();
             mp = (bus.wordCount == 12'd0) ? 3 : 1;
           end
        3: begin mp = 2; m_done = 1'b1; end
        2: mp = 0;
        default: begin
          if (m_q.size() > 0 && bus.memReady) begin
            m_data = m_q.pop_front();
            m_we   = 1'b1;
            m_addr = m_base + m_iss;
            m_iss  = m_iss + 12'd1;
            m_sum  = m_sum + m_data;
          end
          if (bus.convValid) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.convResult);
            else m_ovf = 1'b1;
          end
          if (m_we && m_iss == m_cnt) begin
            mp = 2; m_done = 1'b1; m_q.delete();
          end
        end
      endcase
    end
  end

  // Per-cycle comparison plus a log of issued writes for the directed checks.
  logic [11:0] w_addr[$];
  logic [31:0] w_data[$];
  logic        w_done[$];
  int          w_cyc[$];
  int          done_cyc = -1;
  logic [31:0] sum_at_done = '0;

  always @(negedge clk) begin
    chk("memWe",    bus.memWe,    m_we);
    chk("memAddr",  bus.memAddr,  m_addr);
    chk("memWdata", bus.memWdata, m_data);
    chk("busy",     bus.busy,     (mp == 1));
    chk("done",     bus.done,     m_done);
    chk("overflow", bus.overflow, m_ovf);
`ifdef WR_CHECKSUM_EN
    chk("checksum", bus.checksum, m_sum);
    if (bus.done) sum_at_done = bus.checksum;
`endif
    if (bus.memWe) begin
      w_addr.push_back(bus.memAddr);
      w_data.push_back(bus.memWdata);
      w_done.push_back(bus.done);
      w_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_done.delete(); w_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic start_layer(input logic [11:0] b, input logic [11:0] n, output int s);
    bus.start = 1'b1; bus.baseAddr = b; bus.wordCount = n;
    tick();
    s = cyc;
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, output int s);
    bus.convValid = 1'b1; bus.convResult = d;
    tick();
    s = cyc;
    bus.convValid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (mp != 0 && n < 300) begin tick(); n++; end
    chk(nm, (n < 300), 1'b1);
  endtask

  logic [31:0] bd[4];
  logic [31:0] ov[9];
  int s0, s1, sx;

  initial begin
    bd[0] = 32'h04030201; bd[1] = 32'h08070605; bd[2] = 32'h0C0B0A09; bd[3] = 32'h100F0E0D;
    bus.start = 1'b0; bus.baseAddr = '0; bus.wordCount = '0;
    bus.convValid = 1'b0; bus.convResult = '0; bus.memReady = 1'b1;

    // Reset values
    repeat (3) tick();
    chk("rst_memWe", bus.memWe, 1'b0);
    chk("rst_memAddr", bus.memAddr, 12'h000);
    chk("rst_memWdata", bus.memWdata, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    rst = 1'b1;
    tick();

    // Basic write: four back-to-back beats
    clear_log();
    start_layer(12'h100, 12'd4, s0);
    beat(bd[0], s1);
    for (int i = 1; i < 4; i++) beat(bd[i], sx);
    wait_idle("basic_timeout");
    chk("basic_nwr", w_addr.size(), 4);
    for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
      chk("basic_addr", w_addr[i], 12'h100 + 12'(i));
      chk("basic_data", w_data[i], bd[i]);
      chk("basic_done_align", w_done[i], (i == 3));
    end
    if (w_cyc.size() == 4) begin
      chk("basic_latency", w_cyc[0] - s1, 1);
      chk("basic_throughput", w_cyc[3] - w_cyc[0], 3);
    end

    // convValid while idle is ignored
    clear_log();
    for (int i = 0; i < 3; i++) beat(32'hDEADBEEF, sx);
    tick();
    chk("idle_nwr", w_addr.size(), 0);
    chk("idle_overflow", bus.overflow, 1'b0);

    // Stall: memReady low for 5 edges after the first beat
    clear_log();
    start_layer(12'h100, 12'd4, s0);
    beat(bd[0], s1);
    bus.memReady = 1'b0;
    for (int i = 1; i < 4; i++) beat(bd[i], sx);
    tick(); tick();
    bus.memReady = 1'b1;
    wait_idle("stall_timeout");
    chk("stall_nwr", w_addr.size(), 4);
    for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
      chk("stall_addr", w_addr[i], 12'h100 + 12'(i));
      chk("stall_data", w_data[i], bd[i]);
    end
    if (w_cyc.size() > 0) chk("stall_delay", w_cyc[0] - s1, 6);

    // Overflow: nine beats into an eight-entry FIFO with the SRAM stalled
    clear_log();
    start_layer(12'h200, 12'd8, s0);
    bus.memReady = 1'b0;
    for (int i = 0; i < 9; i++) begin ov[i] = $urandom; beat(ov[i], sx); end
    chk("ovf_set", bus.overflow, 1'b1);
    bus.memReady = 1'b1;
    wait_idle("ovf_timeout");
    chk("ovf_nwr", w_addr.size(), 8);
    for (int i = 0; i < 8 && i < w_data.size(); i++) chk("ovf_data", w_data[i], ov[i]);
    chk("ovf_sticky", bus.overflow, 1'b1);

    // Address wrap; the start also clears overflow
    clear_log();
    start_layer(12'hFFE, 12'd3, s0);
    chk("start_clears_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 3; i++) beat(32'h100 + 32'(i), sx);
    wait_idle("wrap_timeout");
    chk("wrap_nwr", w_addr.size(), 3);
    if (w_addr.size() == 3) begin
      chk("wrap_a0", w_addr[0], 12'hFFE);
      chk("wrap_a1", w_addr[1], 12'hFFF);
      chk("wrap_a2", w_addr[2], 12'h000);
    end

    // Zero word count: done two edges after start, no writes
    clear_log();
    start_layer(12'h050, 12'd0, s0);
    wait_idle("zero_timeout");
    chk("zero_done_lat", done_cyc - s0, 1);
    chk("zero_nwr", w_addr.size(), 0);

    // Reset after two of four writes
    clear_log();
    start_layer(12'h300, 12'd4, s0);
    for (int i = 0; i < 3; i++) beat(bd[i], sx);
    chk("mid_pre_we", bus.memWe, 1'b1);
    chk("mid_pre_addr", bus.memAddr, 12'h301);
    rst = 1'b0;
    #1;
    chk("mid_rst_we", bus.memWe, 1'b0);
    chk("mid_rst_addr", bus.memAddr, 12'h000);
    chk("mid_rst_data", bus.memWdata, 32'h0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    tick(); tick();
    rst = 1'b1;
    clear_log();
    repeat (4) tick();
    chk("mid_rst_nwr", w_addr.size(), 0);

`ifdef WR_CHECKSUM_EN
    clear_log();
    start_layer(12'h000, 12'd4, s0);
    beat(32'h1, sx); beat(32'h2, sx); beat(32'h3, sx); beat(32'hFFFFFFFF, sx);
    wait_idle("csum_timeout");
    chk("checksum_done", sum_at_done, 32'h00000005);
`endif

    // Randomised layers checked cycle by cycle against the model
    for (int l = 0; l < 8; l++) begin
      int n = 0;
      start_layer(12'($urandom_range(0, 4095)), 12'($urandom_range(1, 12)), s0);
      while (mp != 0 && n < 600) begin
        bus.convValid  = ($urandom_range(0, 9) < 6);
        bus.convResult = $urandom;
        bus.memReady   = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      bus.convValid = 1'b0;
      bus.memReady  = 1'b1;
      chk("rand_timeout", (n < 600), 1'b1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
